// File: rtl/pushbutton_debouncer.sv
// Push-button debouncer: debounced level plus single, repeating and continuous
// clock-enable pulse streams, all decoded from a registered Moore FSM.
module pushbutton_debouncer #(
   parameter int N_dc = 21
) (
   input  logic CLK,
   input  logic RESET,
   input  logic PB,
   output logic DPB,
   output logic SCEN,
   output logic MCEN,
   output logic CCEN
);

   localparam int T_DB   = 2 ** (N_dc - 2);
   localparam int T_HOLD = 2 ** (N_dc - 1);
   localparam int T_REP  = 2 ** (N_dc - 2);

   localparam logic [N_dc-1:0] C_ZERO      = '0;
   localparam logic [N_dc-1:0] C_ONE       = (N_dc)'(1);
   localparam logic [N_dc-1:0] C_DB_LAST   = (N_dc)'(T_DB - 1);
   localparam logic [N_dc-1:0] C_HOLD_LAST = (N_dc)'(T_HOLD - 1);
   localparam logic [N_dc-1:0] C_REP_LAST  = (N_dc)'(T_REP - 1);

   localparam logic [2:0] ST_INI = 3'd0;
   localparam logic [2:0] ST_DB  = 3'd1;
   localparam logic [2:0] ST_SC  = 3'd2;
   localparam logic [2:0] ST_WS  = 3'd3;
   localparam logic [2:0] ST_MC  = 3'd4;
   localparam logic [2:0] ST_REP = 3'd5;
   localparam logic [2:0] ST_CCR = 3'd6;

   logic [2:0]      r_state;
   logic [N_dc-1:0] r_cnt;
   logic [2:0]      w_state_nxt;
   logic [N_dc-1:0] w_cnt_nxt;

   // NOTE: every variable written here gets a default first, so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = C_ZERO;
      case (r_state)
         ST_INI: begin
            if (PB) w_state_nxt = ST_DB;
         end
         ST_DB: begin
            if (!PB) begin
               w_state_nxt = ST_INI;
            end else if (r_cnt == C_DB_LAST) begin
               w_state_nxt = ST_SC;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         ST_SC: begin
            w_state_nxt = PB ? ST_WS : ST_CCR;
         end
         ST_WS: begin
            if (!PB) begin
               w_state_nxt = ST_CCR;
            end else if (r_cnt == C_HOLD_LAST) begin
               w_state_nxt = ST_MC;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         ST_MC: begin
            w_state_nxt = PB ? ST_REP : ST_CCR;
         end
         ST_REP: begin
            if (!PB) begin
               w_state_nxt = ST_CCR;
            end else if (r_cnt == C_REP_LAST) begin
               w_state_nxt = ST_MC;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         ST_CCR: begin
            // A bounce back high only restarts the release timer; it never re-arms a press.
            if (!PB && r_cnt == C_DB_LAST) begin
               w_state_nxt = ST_INI;
            end else if (!PB) begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_INI;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_INI;
         r_cnt   <= C_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Moore decode: outputs depend on the registered state only, never on PB.
   always_comb begin
      DPB  = 1'b0;
      SCEN = 1'b0;
      MCEN = 1'b0;
      CCEN = 1'b0;
      case (r_state)
         ST_SC: begin
            DPB  = 1'b1;
            SCEN = 1'b1;
            MCEN = 1'b1;
            CCEN = 1'b1;
         end
         ST_WS:  DPB = 1'b1;
         ST_MC: begin
            DPB  = 1'b1;
            MCEN = 1'b1;
            CCEN = 1'b1;
         end
         ST_REP: begin
            DPB  = 1'b1;
            CCEN = 1'b1;
         end
         ST_CCR: DPB = 1'b1;
         default: begin
            DPB  = 1'b0;
            SCEN = 1'b0;
            MCEN = 1'b0;
            CCEN = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Self-checking bench for pushbutton_debouncer: directed scenarios with literal
// expectations plus randomized button activity compared against a timing model.
module tb_pushbutton_debouncer;

   localparam int N_DC   = 4;
   localparam int T_DB   = 4;
   localparam int T_HOLD = 8;
   localparam int T_REP  = 4;

   localparam int M_IDLE  = 0;
   localparam int M_PRESS = 1;
   localparam int M_REL   = 2;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   logic PB    = 1'b0;
   logic DPB, SCEN, MCEN, CCEN;

   int n_checks = 0;
   int n_errors = 0;

   // Model: consecutive-high count while idle, cycles since the press pulse,
   // consecutive-low count while releasing.
   int m_mode  = M_IDLE;
   int m_run   = 0;
   int m_held  = 0;
   int m_low   = 0;
   bit m_valid = 1'b0;

   pushbutton_debouncer #(.N_dc(N_DC)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .PB   (PB),
      .DPB  (DPB),
      .SCEN (SCEN),
      .MCEN (MCEN),
      .CCEN (CCEN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] model_vec();
      logic mc, cc;
      case (m_mode)
         M_PRESS: begin
            cc = (m_held == 0) || (m_held >= T_HOLD + 1);
            mc = (m_held == 0) ||
                 ((m_held >= T_HOLD + 1) && ((m_held - (T_HOLD + 1)) % (T_REP + 1) == 0));
            return {1'b1, (m_held == 0), mc, cc};
         end
         M_REL:   return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   always @(posedge CLK) begin
      if (RESET) begin
         m_mode  = M_IDLE;
         m_run   = 0;
         m_valid = 1'b1;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (PB) begin
                  m_run = m_run + 1;
                  if (m_run == T_DB + 1) begin
                     m_mode = M_PRESS;
                     m_held = 0;
                  end
               end else begin
                  m_run = 0;
               end
            end
            M_PRESS: begin
               if (PB) m_held = m_held + 1;
               else begin
                  m_mode = M_REL;
                  m_low  = 0;
               end
            end
            default: begin
               if (PB) m_low = 0;
               else begin
                  m_low = m_low + 1;
                  if (m_low == T_DB) begin
                     m_mode = M_IDLE;
                     m_run  = 0;
                  end
               end
            end
         endcase
      end
   end

   always @(negedge CLK) begin
      if (m_valid) check("model", int'({DPB, SCEN, MCEN, CCEN}), int'(model_vec()));
   end

   task automatic cyc(input logic pb, input logic rst);
      PB    = pb;
      RESET = rst;
      @(posedge CLK);
      #1;
   endtask

   function automatic int outs();
      return int'({DPB, SCEN, MCEN, CCEN});
   endfunction

   initial begin
      int mc_q[$];
      int exp_mc[7];
      int cc_cnt, sc_cnt, pulses, total;
      logic [1:0] bounce[6];
      exp_mc = '{5, 14, 19, 24, 29, 34, 39};
      bounce = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

      // Reset with the button held.
      cyc(1'b1, 1'b1);
      check("reset_c0", outs(), 4'b0000);
      cyc(1'b1, 1'b1);
      check("reset_c1", outs(), 4'b0000);

      // Clean short press, 12 high samples then release.
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b1, 1'b0);
         if (i < 5)  check("short_pre_scen", int'(SCEN), 0);
         if (i == 5) check("short_sc", outs(), 4'b1111);
         if (i == 6) check("short_ws", outs(), 4'b1000);
      end
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b0, 1'b0);
         if (i == 4) check("short_rel_dpb_hi", int'(DPB), 1);
         if (i == 5) check("short_rel_dpb_lo", int'(DPB), 0);
      end

      // Bounce on press: glitch restarts the debounce.
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      check("bounce_press_idle", outs(), 4'b0000);
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b1, 1'b0);
         if (i == 4) check("bounce_press_pre", int'(SCEN), 0);
         if (i == 5) check("bounce_press_sc", outs(), 4'b1111);
      end
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);

      // Long hold: repeating MCEN and continuous CCEN.
      cc_cnt = 0;
      sc_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         cyc(1'b1, 1'b0);
         if (MCEN) mc_q.push_back(i);
         if (CCEN) cc_cnt++;
         if (SCEN) sc_cnt++;
      end
      check("hold_mc_count", mc_q.size(), 7);
      for (int k = 0; k < 7 && k < mc_q.size(); k++) check("hold_mc_time", mc_q[k], exp_mc[k]);
      check("hold_cc_count", cc_cnt, 28);
      check("hold_sc_count", sc_cnt, 1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);

      // Bounce on release: no extra pulses, DPB holds until 4 trailing lows in CCR.
      for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0);
      check("relb_sc", outs(), 4'b1111);
      pulses = 0;
      for (int j = 0; j < 6; j++) begin
         cyc(bounce[j][0], 1'b0);
         pulses += int'(SCEN) + int'(MCEN) + int'(CCEN);
         if (j == 4) check("relb_dpb_hi", int'(DPB), 1);
         if (j == 5) check("relb_dpb_lo", int'(DPB), 0);
      end
      check("relb_pulses", pulses, 0);

      // Reset mid-hold while repeating.
      for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0);
      check("midhold_rep", outs(), 4'b1001);
      cyc(1'b1, 1'b1);
      check("midhold_reset", outs(), 4'b0000);
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b1, 1'b0);
         if (i < 5)  check("midhold_pre", outs(), 4'b0000);
         if (i == 5) check("midhold_sc", outs(), 4'b1111);
      end
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);

      // Randomized bursts: glitches, short and long presses, occasional reset.
      total = 0;
      while (total < 4000) begin
         int len;
         logic lvl;
         lvl = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       len = $urandom_range(1, 3);
            1:       len = $urandom_range(4, 8);
            2:       len = $urandom_range(9, 20);
            default: len = $urandom_range(21, 45);
         endcase
         for (int i = 0; i < len; i++) begin
            cyc(lvl, ($urandom_range(0, 199) == 0));
            total++;
         end
      end
      cyc(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
